sha512_msg_padder: RTL and testbench

- Sits directly downstream of the read engine (S_RD_* FSM); consumes the 512-bit cache lines (t_block) fetched from the HC input buffer.
- Pairs lines into 1024-bit SHA-512 message blocks and applies FIPS 180-4 padding: 0x80, zero fill, then a 128-bit big-endian bit length.
- Feeds the SHA-512 compression core over a valid/ready interface. The message length comes from the HC buffer descriptor size field, in bytes.

---
 rtl/sha512_msg_padder.sv | 160 ++++++++++++++++
 tb/tb_sha512_msg_padder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: pairs 512-bit read-engine lines into 1024-bit blocks and
// appends 0x80, zero fill and the 128-bit big-endian bit length.
module sha512_msg_padder #(
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             SoftReset,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [511:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1023:0]    out_block,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int LL_W   = LEN_W - 5;
   localparam int BASE_W = LEN_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FILL_LO, S_FILL_HI, S_BUILD, S_EMIT, S_PAD_ONLY, S_DONE
   } state_t;

   state_t              r_state, w_next;
   logic [LEN_W-1:0]    r_len;
   logic [LL_W-1:0]     r_lines_left;
   logic [BASE_W-1:0]   r_base;        // byte index of the current block's first byte
   logic [511:0]        r_lo, r_hi;
   logic [1023:0]       r_block;
   logic                r_last;

   logic [BASE_W-1:0]   w_ll_init, w_line_base, w_line_rem, w_rem;
   logic [511:0]        w_masked;
   logic [1023:0]       w_data, w_build, w_pad_blk;
   logic [127:0]        w_bitlen;
   logic                w_final;

   assign w_ll_init   = {1'b0, msg_len} + BASE_W'(63);
   assign w_line_base = r_base + ((r_state == S_FILL_HI) ? BASE_W'(64) : BASE_W'(0));
   assign w_line_rem  = {1'b0, r_len} - w_line_base;
   assign w_rem       = {1'b0, r_len} - r_base;
   assign w_bitlen    = 128'({r_len, 3'b000});
   assign w_final     = (w_rem <= BASE_W'(111));
   assign w_data      = {r_hi, r_lo};
   assign w_pad_blk   = {((r_base == {1'b0, r_len}) ? 8'h80 : 8'h00), 888'b0, w_bitlen};

   // Bytes at or beyond the message length never reach the block.
   always_comb begin
      w_masked = '0;
      for (int k = 0; k < 64; k++)
         w_masked[8*k +: 8] = (BASE_W'(k) < w_line_rem) ? in_data[8*k +: 8] : 8'h00;
   end

   // Line byte order is little-endian, block byte order is big-endian.
   always_comb begin
      w_build = '0;
      for (int b = 0; b < 128; b++)
         w_build[1023-8*b -: 8] = (w_rem == BASE_W'(b)) ? 8'h80 : w_data[8*b +: 8];
      if (w_final)
         w_build[127:0] = w_bitlen;
   end

   always_ff @(posedge clk) begin
      if (SoftReset) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_FILL_LO;
         end
         S_FILL_LO: begin
            in_ready = (r_lines_left != '0);
            if (r_lines_left == '0)
               w_next = S_BUILD;
            else if (in_valid)
               w_next = (r_lines_left > LL_W'(1)) ? S_FILL_HI : S_BUILD;
         end
         S_FILL_HI: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_BUILD;
         end
         S_BUILD:    w_next = S_EMIT;
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (r_last)                   w_next = S_DONE;
               else if (r_lines_left == '0) w_next = S_PAD_ONLY;
               else                          w_next = S_FILL_LO;
            end
         end
         S_PAD_ONLY: w_next = S_EMIT;
         S_DONE: begin
            busy   = 1'b0;
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         r_len        <= '0;
         r_lines_left <= '0;
         r_base       <= '0;
         r_lo         <= '0;
         r_hi         <= '0;
         r_block      <= '0;
         r_last       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_len        <= msg_len;
               r_lines_left <= w_ll_init[BASE_W-1:6];
               r_base       <= '0;
            end
            S_FILL_LO: begin
               if (r_lines_left == '0) begin
                  r_lo <= '0;
                  r_hi <= '0;
               end else if (in_valid) begin
                  r_lo         <= w_masked;
                  r_hi         <= '0;
                  r_lines_left <= r_lines_left - LL_W'(1);
               end
            end
            S_FILL_HI: if (in_valid) begin
               r_hi         <= w_masked;
               r_lines_left <= r_lines_left - LL_W'(1);
            end
            S_BUILD: begin
               r_block <= w_build;
               r_last  <= w_final;
            end
            S_PAD_ONLY: begin
               r_block <= w_pad_blk;
               r_last  <= 1'b1;
            end
            S_EMIT: if (out_ready) r_base <= r_base + BASE_W'(128);
            default: ;
         endcase
      end
   end

   assign out_block = r_block;
   assign out_last  = r_last & (r_state == S_EMIT);

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Bench for sha512_msg_padder: expected blocks come from a flat byte-array model of
// standard SHA-512 padding (message, 0x80, zeros, 16-byte big-endian bit length).
module tb_sha512_msg_padder;

   logic          clk = 1'b0;
   logic          SoftReset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   msg_len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [511:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1023:0] out_block;
   logic          out_last;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   logic [7:0] msg [0:1023];
   logic [7:0] pad [0:1279];
   int         n_blocks;

   sha512_msg_padder #(.LEN_W(32)) dut (
      .clk(clk), .SoftReset(SoftReset), .start(start), .msg_len(msg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic build_model(input int len, input int pattern);
      int total;
      logic [127:0] bl;
      for (int i = 0; i < 1024; i++)
         msg[i] = (pattern == 1) ? 8'(i) : (pattern == 2) ? 8'(8'h61 + i) : 8'($urandom);
      total = ((len + 17 + 127) / 128) * 128;
      n_blocks = total / 128;
      for (int i = 0; i < total; i++)
         pad[i] = (i < len) ? msg[i] : (i == len) ? 8'h80 : 8'h00;
      bl = 128'(len) << 3;
      for (int j = 0; j < 16; j++)
         pad[total-16+j] = bl[127-8*j -: 8];
   endtask

   function automatic logic [1023:0] exp_block(input int b);
      logic [1023:0] r;
      for (int i = 0; i < 128; i++)
         r[1023-8*i -: 8] = pad[b*128+i];
      return r;
   endfunction

   task automatic drive_line(input int li, input int len, input int pattern);
      int idx;
      for (int k = 0; k < 64; k++) begin
         idx = li*64 + k;
         in_data[8*k +: 8] = (idx < len) ? msg[idx] : ((pattern == 0) ? 8'($urandom) : 8'hFF);
      end
   endtask

   task automatic run_msg(input int len, input int extra, input int pattern,
                          input bit rnd, input bit stall);
      int nlines, n_offer, li, acc, blk, cyc, stall_left;
      bit fin, saw_rdy;
      nlines = (len + 63) / 64;
      n_offer = nlines + extra;
      li = 0; acc = 0; blk = 0; cyc = 0; stall_left = 10; fin = 0; saw_rdy = 0;
      build_model(len, pattern);
      @(negedge clk); start = 1'b1; msg_len = 32'(len);
      @(negedge clk); start = 1'b0; msg_len = $urandom;
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL busy_after_start len=%0d got=%b want=1", len, busy);
      end
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         in_valid = (li < n_offer) && (!rnd || $urandom_range(0, 3) != 0);
         drive_line(li, len, pattern);
         out_ready = (stall && stall_left > 0) ? 1'b0 : (!rnd || $urandom_range(0, 2) != 0);
         start = rnd && ($urandom_range(0, 7) == 0);
         msg_len = $urandom;
         #1;
         if (in_ready) saw_rdy = 1;
         if (stall && stall_left > 0 && (out_valid || stall_left < 10)) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== exp_block(0)) begin
               errors++;
               $display("FAIL stall_hold len=%0d ov=%b ir=%b blk_ok=%b want ov=1 ir=0 blk_ok=1",
                        len, out_valid, in_ready, out_block === exp_block(0));
            end
            stall_left--;
         end
         if (in_valid && in_ready) begin acc++; li++; end
         if (out_valid && out_ready) begin
            checks++;
            if (blk >= n_blocks || out_block !== exp_block(blk) || out_last !== (blk == n_blocks-1)) begin
               errors++;
               $display("FAIL block len=%0d idx=%0d got=%h last=%b want=%h last=%b", len, blk,
                        out_block, out_last, (blk < n_blocks) ? exp_block(blk) : '0, blk == n_blocks-1);
            end
            blk++;
         end
         if (done) fin = 1;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (!fin) begin errors++; $display("FAIL timeout len=%0d got=no_done want=done", len); end
      checks++;
      if (acc != nlines) begin
         errors++; $display("FAIL lines_accepted len=%0d got=%0d want=%0d", len, acc, nlines);
      end
      checks++;
      if (blk != n_blocks) begin
         errors++; $display("FAIL block_count len=%0d got=%0d want=%0d", len, blk, n_blocks);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done len=%0d got=%b want=0", len, busy); end
      if (len == 0) begin
         checks++;
         if (saw_rdy) begin errors++; $display("FAIL zero_len_in_ready got=1 want=0"); end
      end
   endtask

   task automatic test_reset();
      SoftReset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_block !== '0) begin
         errors++;
         $display("FAIL reset_state got ir=%b ov=%b ol=%b busy=%b done=%b blk_zero=%b want all 0",
                  in_ready, out_valid, out_last, busy, done, out_block === '0);
      end
      SoftReset = 1'b0;
   endtask

   task automatic test_fixed();
      run_msg(3,   1, 2, 1'b0, 1'b0);
      run_msg(0,   1, 0, 1'b0, 1'b0);
      run_msg(111, 0, 0, 1'b0, 1'b0);
      run_msg(112, 0, 1, 1'b0, 1'b0);
      run_msg(128, 1, 1, 1'b0, 1'b0);
      run_msg(64,  2, 0, 1'b0, 1'b0);
      run_msg(240, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_msg(200, 1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++)
         run_msg($urandom_range(0, 700), $urandom_range(0, 2), 0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_emit();
      int li, cyc;
      li = 0; cyc = 0;
      build_model(200, 0);
      @(negedge clk); start = 1'b1; msg_len = 32'd200;
      @(negedge clk); start = 1'b0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b1;
         drive_line(li, 200, 0);
         out_ready = 1'b0;
         #1;
         if (out_valid) break;
         if (in_ready) li++;
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL reach_emit got=%b want=1", out_valid); end
      in_valid = 1'b0;
      SoftReset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_emit got ov=%b busy=%b ir=%b want 0 0 0", out_valid, busy, in_ready);
      end
      SoftReset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got ov=%b busy=%b want 0 0", out_valid, busy);
      end
      run_msg(3, 1, 2, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_backpressure();
      test_random();
      test_reset_mid_emit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
